// File: rtl/bconv_pkg.sv
// Shared constants, types and helpers for the binary 3x3 convolution engine.
package bconv_pkg;

  // Window geometry: tap i sits at row offset i/3 and column offset i%3
  // behind the newest pixel.
  localparam int NUM_TAPS = 9;
  localparam int TAP_ROW0 = 0;   // taps 0..2: current row, cols c..c-2
  localparam int TAP_ROW1 = 3;   // taps 3..5: row r-1
  localparam int TAP_ROW2 = 6;   // taps 6..8: row r-2

  // Register-file address that selects the bias instead of a tap weight.
  localparam logic [3:0] BIAS_ADDR = 4'd9;

  // One 3x3 window of binary pixels, bit i feeds tap i.
  typedef logic [NUM_TAPS-1:0] win_t;

  // Tap weights of one kernel, stored sign-extended to 32 bits. Module-level
  // arrays narrow this down to their own WW/OUT_W widths.
  typedef logic signed [31:0] tap_row_t [NUM_TAPS];

  // Clamp a signed value into the range of a w-bit two's-complement number.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v,
                                                    input int unsigned    w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/bconv_window.sv
// Line buffer, raster position tracking and 3x3 window extraction for a
// 1-bit pixel stream. The window and its flags are combinational on the
// accepted pixel; the consumer registers them.
module bconv_window
  import bconv_pkg::*;
#(
  parameter int IMG_W = 34,
  parameter int IMG_H = 34
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_din_valid,
  input  logic i_din,
  input  logic i_sof,
  output win_t o_win,
  output logic o_win_valid,
  output logic o_win_eof
);

  // The oldest tap needed is 2*IMG_W+2 pixels back, which is the top bit of
  // {buffer, din}; the buffer itself only has to remember 2*IMG_W+2 pixels.
  localparam int LB_LEN = 2 * IMG_W + 2;
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);

  logic [LB_LEN-1:0] r_lb;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [LB_LEN:0]   w_taps;
  logic [CW-1:0]     w_col;
  logic [RW-1:0]     w_row;
  logic [CW-1:0]     w_col_nxt;
  logic [RW-1:0]     w_row_nxt;

  assign w_taps = {r_lb, i_din};

  // A start-of-frame pixel is position (0,0) whatever the counters say.
  assign w_col = i_sof ? '0 : r_col;
  assign w_row = i_sof ? '0 : r_row;

  // Raster advance: column wraps into the next row, last pixel wraps the frame.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    w_col_nxt = w_col + CW'(1);
    w_row_nxt = w_row;
    if (w_col == CW'(IMG_W - 1)) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row == RW'(IMG_H - 1)) ? '0 : w_row + RW'(1);
    end
  end

  // Shift the buffer and step the counters only on accepted pixels.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lb  <= '0;
      r_col <= '0;
      r_row <= '0;
    end else if (i_din_valid) begin
      r_lb  <= w_taps[LB_LEN-1:0];
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
    end
  end

  // Pick the three 3-pixel runs that form rows r, r-1 and r-2 of the window.
  always_comb begin
    o_win = '0;
    for (int j = 0; j < 3; j++) begin
      o_win[TAP_ROW0 + j] = w_taps[j];
      o_win[TAP_ROW1 + j] = w_taps[IMG_W + j];
      o_win[TAP_ROW2 + j] = w_taps[2 * IMG_W + j];
    end
  end

  // Interior windows only; edge windows would wrap across lines.
  assign o_win_valid = i_din_valid && (w_row >= RW'(2)) && (w_col >= CW'(2));
  assign o_win_eof   = o_win_valid && (w_row == RW'(IMG_H - 1)) &&
                       (w_col == CW'(IMG_W - 1));

endmodule

// File: rtl/bin_conv3x3_stream.sv
// Binary-input 3x3 convolution engine: NUM_K kernels with run-time signed
// weights and bias over a raster 1-bit pixel stream, saturated outputs.
// Optional build macro: BCONV_RELU_EN clamps negative results to 0.
module bin_conv3x3_stream
  import bconv_pkg::*;
#(
  parameter int IMG_W = 34,
  parameter int IMG_H = 34,
  parameter int NUM_K = 4,
  parameter int WW    = 4,
  parameter int OUT_W = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     din_valid,
  input  logic                     din,
  input  logic                     sof,
  input  logic                     w_we,
  input  logic [$clog2(NUM_K)-1:0] w_k,
  input  logic [3:0]               w_addr,
  input  logic [OUT_W-1:0]         w_data,
  output logic                     dout_valid,
  output logic [NUM_K*OUT_W-1:0]   dout,
  output logic                     dout_eof
);

  typedef logic signed [WW-1:0]    weight_t;
  typedef logic signed [OUT_W-1:0] bias_t;

  weight_t                  r_w    [NUM_K][NUM_TAPS];
  bias_t                    r_bias [NUM_K];
  win_t                     w_win;
  logic                     w_win_valid;
  logic                     w_win_eof;
  logic signed [OUT_W:0]    w_acc  [NUM_K];
  logic signed [OUT_W-1:0]  w_sat  [NUM_K];
  logic [NUM_K*OUT_W-1:0]   w_res;

  bconv_window #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_window (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_din_valid (din_valid),
    .i_din       (din),
    .i_sof       (sof),
    .o_win       (w_win),
    .o_win_valid (w_win_valid),
    .o_win_eof   (w_win_eof)
  );

  // Weight/bias register file; addresses 10..15 fall through and are ignored.
  // NOTE: this storage is flops, not RAM, and must come up as all-zero
  // kernels, so it takes the reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_K; k++) begin
        r_bias[k] <= '0;
        for (int i = 0; i < NUM_TAPS; i++) r_w[k][i] <= '0;
      end
    end else if (w_we) begin
      if (w_addr == BIAS_ADDR)     r_bias[w_k]         <= w_data;
      else if (w_addr < BIAS_ADDR) r_w[w_k][w_addr]    <= w_data[WW-1:0];
    end
  end

  // Per kernel: bias plus the weights of set window bits, one bit of
  // headroom, then saturation (and optional ReLU).
  always_comb begin
    w_res = '0;
    for (int k = 0; k < NUM_K; k++) begin
      w_acc[k] = {r_bias[k][OUT_W-1], r_bias[k]};
      for (int i = 0; i < NUM_TAPS; i++) begin
        if (w_win[i])
          w_acc[k] = w_acc[k] + {{(OUT_W + 1 - WW){r_w[k][i][WW-1]}}, r_w[k][i]};
      end
      w_sat[k] = OUT_W'(sat_signed(32'(w_acc[k]), OUT_W));
`ifdef BCONV_RELU_EN
      if (w_sat[k][OUT_W-1]) w_sat[k] = '0;
`else
      w_sat[k] = w_sat[k];
`endif
      w_res[k*OUT_W +: OUT_W] = w_sat[k];
    end
  end

  // Output stage: one-cycle valid pulse, data and eof held between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_eof   <= 1'b0;
    end else begin
      dout_valid <= w_win_valid;
      if (w_win_valid) begin
        dout     <= w_res;
        dout_eof <= w_win_eof;
      end
    end
  end

endmodule

// File: tb/tb_bin_conv3x3_stream.sv
// Self-checking bench for bin_conv3x3_stream: directed frames against a
// bench-side image model with hand-computed spot values.
module tb_bin_conv3x3_stream;

  localparam int W  = 34;
  localparam int H  = 34;
  localparam int K  = 4;
  localparam int WW = 4;
  localparam int OW = 10;
  localparam int NOUT = (W - 2) * (H - 2);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            din_valid, din, sof, w_we;
  logic [1:0]      w_k;
  logic [3:0]      w_addr;
  logic [OW-1:0]   w_data;
  logic            dout_valid;
  logic [K*OW-1:0] dout;
  logic            dout_eof;

  int checks = 0;
  int errors = 0;

  int m_w    [K][9];
  int m_bias [K];
  bit m_img  [H][W];
  int m_r, m_c;

  logic [K*OW:0] got_q [$];
  logic [K*OW:0] exp_q [$];
  logic [K*OW:0] v;

  bin_conv3x3_stream #(
    .IMG_W (W), .IMG_H (H), .NUM_K (K), .WW (WW), .OUT_W (OW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din        (din),
    .sof        (sof),
    .w_we       (w_we),
    .w_k        (w_k),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .dout_valid (dout_valid),
    .dout       (dout),
    .dout_eof   (dout_eof)
  );

  always #5 clk = ~clk;

  // Capture every output pulse away from the active edge.
  always @(negedge clk)
    if (rst_n === 1'b1 && dout_valid === 1'b1) got_q.push_back({dout_eof, dout});

  function automatic logic [K*OW-1:0] model_out(int r, int c);
    logic [K*OW-1:0] o;
    int acc;
    o = '0;
    for (int k = 0; k < K; k++) begin
      acc = m_bias[k];
      for (int i = 0; i < 9; i++)
        if (m_img[r - i / 3][c - i % 3]) acc += m_w[k][i];
      if (acc > 511)  acc = 511;
      if (acc < -512) acc = -512;
`ifdef BCONV_RELU_EN
      if (acc < 0) acc = 0;
`endif
      o[k*OW +: OW] = acc[OW-1:0];
    end
    return o;
  endfunction

  task automatic idle(input int n);
    din_valid = 1'b0; sof = 1'b0; w_we = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    din_valid = 1'b0; din = 1'b0; sof = 1'b0;
    w_we = 1'b0; w_k = '0; w_addr = '0; w_data = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    foreach (m_w[k, i]) m_w[k][i] = 0;
    foreach (m_bias[k]) m_bias[k] = 0;
    m_r = 0; m_c = 0;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic write_w(input int k, input int addr, input int data);
    w_we = 1'b1; w_k = 2'(k); w_addr = 4'(addr); w_data = data[OW-1:0];
    @(posedge clk); #1;
    w_we = 1'b0;
    if (addr < 9)       m_w[k][addr] = $signed(data[WW-1:0]);
    else if (addr == 9) m_bias[k]    = $signed(data[OW-1:0]);
  endtask

  // One accepted pixel, optionally with a coincident write of w[0][0].
  task automatic send_pixel(input bit d, input bit s, input bit we, input int wdata);
    din_valid = 1'b1; din = d; sof = s;
    w_we = we; w_k = 2'd0; w_addr = 4'd0; w_data = wdata[OW-1:0];
    if (s) begin m_r = 0; m_c = 0; end
    m_img[m_r][m_c] = d;
    if (m_r >= 2 && m_c >= 2)
      exp_q.push_back({1'(m_r == H - 1 && m_c == W - 1), model_out(m_r, m_c)});
    if (m_c == W - 1) begin
      m_c = 0;
      m_r = (m_r == H - 1) ? 0 : m_r + 1;
    end else m_c++;
    if (we) m_w[0][0] = $signed(wdata[WW-1:0]);
    @(posedge clk); #1;
    din_valid = 1'b0; sof = 1'b0; w_we = 1'b0;
  endtask

  // mode: 0 zeros, 1 ones, 2 single 1 at (5,5), 3 random.
  task automatic send_frame(input int mode, input int gap_max, input int npix,
                            input bit sof_first, input int wr_idx, input int wr_data);
    bit d;
    for (int p = 0; p < npix; p++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          din_valid = 1'b0; sof = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        sof = 1'b0;
      end
      case (mode)
        0:       d = 1'b0;
        1:       d = 1'b1;
        2:       d = (p == 5 * W + 5);
        default: d = 1'($urandom_range(0, 1));
      endcase
      send_pixel(d, sof_first && p == 0, p == wr_idx, wr_data);
    end
  endtask

  task automatic test_reset();
    din_valid = 1'b0; din = 1'b0; sof = 1'b0;
    w_we = 1'b0; w_k = '0; w_addr = '0; w_data = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
    checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout: got %h want 0", dout); end
    checks++; if (dout_eof !== 1'b0) begin errors++; $display("FAIL reset_eof: got %b want 0", dout_eof); end
    apply_reset();
    idle(3);
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL reset_idle_pulses: got %0d want 0", got_q.size()); end
  endtask

  task automatic test_zero_frame();
    int neof;
    write_w(0, 9, 5);
    write_w(1, 12, 100);   // ignored address
    send_frame(0, 0, W * H, 1'b1, -1, 0);
    idle(4);
    checks++; if (got_q.size() !== 1024) begin errors++; $display("FAIL zero_count: got %0d want 1024", got_q.size()); end
    v = (got_q.size() > 0) ? got_q[0] : 'x;
    checks++; if (v !== {1'b0, 30'd0, 10'd5}) begin errors++; $display("FAIL zero_first: got %h want k0=5", v); end
    neof = 0;
    foreach (got_q[i]) if (got_q[i][K*OW]) neof++;
    checks++; if (neof !== 1) begin errors++; $display("FAIL zero_eof_count: got %0d want 1", neof); end
    v = (got_q.size() > 1023) ? got_q[1023] : 'x;
    checks++; if (v[K*OW] !== 1'b1) begin errors++; $display("FAIL zero_eof_last: got %b want 1", v[K*OW]); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL zero_model_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL zero_out[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 9; i++) begin
      write_w(0, i, -8);
      write_w(1, i, 7);
      write_w(2, i, -8);
      write_w(3, i, 7);
    end
    write_w(0, 9, -500);   // -72-500 = -572 -> -512
    write_w(2, 9, -200);   // -72-200 = -272, in range
    write_w(3, 9, 511);    //  63+511 =  574 ->  511
    // No sof: the counters wrapped at the end of the previous frame.
    send_frame(1, 0, W * H, 1'b0, -1, 0);
    idle(4);
    v = (got_q.size() > 0) ? got_q[0] : 'x;
`ifdef BCONV_RELU_EN
    checks++; if (v[9:0] !== 10'd0) begin errors++; $display("FAIL sat_neg: got %h want 000", v[9:0]); end
    checks++; if (v[29:20] !== 10'd0) begin errors++; $display("FAIL sat_mid: got %h want 000", v[29:20]); end
`else
    checks++; if (v[9:0] !== 10'h200) begin errors++; $display("FAIL sat_neg: got %h want 200", v[9:0]); end
    checks++; if (v[29:20] !== 10'h2F0) begin errors++; $display("FAIL sat_mid: got %h want 2f0", v[29:20]); end
`endif
    checks++; if (v[19:10] !== 10'd63) begin errors++; $display("FAIL sat_k1: got %0d want 63", v[19:10]); end
    checks++; if (v[39:30] !== 10'h1FF) begin errors++; $display("FAIL sat_pos: got %h want 1ff", v[39:30]); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL sat_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL sat_out[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_single_pixel();
    apply_reset();
    for (int i = 0; i < 9; i++) write_w(0, i, i);   // 8 wraps to -8 in 4 bits
    send_frame(2, 0, W * H, 1'b1, -1, 0);
    idle(4);
    // Output index of (r,c) is (r-2)*32 + (c-2).
    v = (got_q.size() > 99)  ? got_q[99]  : 'x;
    checks++; if (v[9:0] !== 10'd0) begin errors++; $display("FAIL single_5_5: got %h want 0", v[9:0]); end
    v = (got_q.size() > 101) ? got_q[101] : 'x;
    checks++; if (v[9:0] !== 10'd2) begin errors++; $display("FAIL single_5_7: got %h want 2", v[9:0]); end
    v = (got_q.size() > 131) ? got_q[131] : 'x;
    checks++; if (v[9:0] !== 10'd3) begin errors++; $display("FAIL single_6_5: got %h want 3", v[9:0]); end
    v = (got_q.size() > 132) ? got_q[132] : 'x;
    checks++; if (v[9:0] !== 10'd4) begin errors++; $display("FAIL single_6_6: got %h want 4", v[9:0]); end
    v = (got_q.size() > 165) ? got_q[165] : 'x;
`ifdef BCONV_RELU_EN
    checks++; if (v[9:0] !== 10'd0) begin errors++; $display("FAIL single_7_7: got %h want 0", v[9:0]); end
`else
    checks++; if (v[9:0] !== 10'h3F8) begin errors++; $display("FAIL single_7_7: got %h want 3f8", v[9:0]); end
`endif
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL single_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_out[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_weight_timing();
    apply_reset();
    write_w(0, 0, 1);
    // Write w[0][0]=3 in the same cycle as pixel (10,10).
    send_frame(1, 0, W * H, 1'b1, 10 * W + 10, 3);
    idle(4);
    v = (got_q.size() > 263) ? got_q[263] : 'x;
    checks++; if (v[9:0] !== 10'd1) begin errors++; $display("FAIL wt_before: got %0d want 1", v[9:0]); end
    v = (got_q.size() > 264) ? got_q[264] : 'x;
    checks++; if (v[9:0] !== 10'd1) begin errors++; $display("FAIL wt_same_cycle: got %0d want 1", v[9:0]); end
    v = (got_q.size() > 265) ? got_q[265] : 'x;
    checks++; if (v[9:0] !== 10'd3) begin errors++; $display("FAIL wt_after: got %0d want 3", v[9:0]); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL wt_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL wt_out[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_gaps_sof();
    int neof;
    int k1w [9] = '{1, -2, 3, -4, 5, -6, 7, -8, 2};
    for (int i = 0; i < 9; i++) begin
      write_w(1, i, k1w[i]);
      write_w(2, i, -8);
      write_w(3, i, 7);
    end
    write_w(1, 9, 17);
    write_w(2, 9, -500);
    write_w(3, 9, 480);
    // 500 pixels (rows 0..13 plus 24 of row 14), then sof restarts the frame.
    send_frame(3, 3, 500, 1'b1, -1, 0);
    send_frame(3, 3, W * H, 1'b1, -1, 0);
    idle(4);
    checks++; if (got_q.size() !== 406 + NOUT) begin errors++; $display("FAIL gaps_count: got %0d want %0d", got_q.size(), 406 + NOUT); end
    neof = 0;
    foreach (got_q[i]) if (got_q[i][K*OW]) neof++;
    checks++; if (neof !== 1) begin errors++; $display("FAIL gaps_eof_count: got %0d want 1", neof); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL gaps_model_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL gaps_out[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_saturation();
    test_single_pixel();
    test_weight_timing();
    test_gaps_sof();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
